// File: rtl/ub_sched_pkg.sv
// ----------------------------------------------------------------------------
// ub_sched_pkg
// Shared definitions for the unified-buffer port schedule generator:
//   - NDIM_DEF / W_DEF : default loop depth and datapath width
//   - sched_state_e    : schedule FSM states
// ----------------------------------------------------------------------------
package ub_sched_pkg;

  localparam int NDIM_DEF = 4;
  localparam int W_DEF    = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } sched_state_e;

endpackage

// File: rtl/ub_sched_nest_cnt.sv
// ----------------------------------------------------------------------------
// ub_sched_nest_cnt
// NDIM-level loop-nest counter. Dimension NDIM-1 is innermost and steps
// fastest; each dimension wraps to 0 at extent-1 and carries outward.
// Ports:
//   clk, rst_n   clock / synchronous active-low reset
//   clr          load the all-zero point (priority over inc)
//   inc          advance to the next point
//   extent[]     trip count per dimension (must be non-zero while counting)
//   cnt[]        current point (registered)
//   nxt[]        point that inc would load (combinational)
//   last         current point is (extent[i]-1) in every dimension
// ----------------------------------------------------------------------------
module ub_sched_nest_cnt
  import ub_sched_pkg::*;
#(
  parameter int NDIM = NDIM_DEF,
  parameter int W    = W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] extent [NDIM-1:0],
  output logic [W-1:0] cnt    [NDIM-1:0],
  output logic [W-1:0] nxt    [NDIM-1:0],
  output logic         last
);

  logic [W-1:0]    cnt_q [NDIM-1:0];
  logic [W-1:0]    cnt_d [NDIM-1:0];
  logic [NDIM-1:0] at_max;
  // carry[k] is the carry into dimension k-1; the innermost always steps.
  logic [NDIM:1]   carry;

  assign carry[NDIM] = 1'b1;

  generate
    for (genvar gi = 0; gi < NDIM; gi++) begin : g_dim
      assign at_max[gi] = (cnt_q[gi] == extent[gi] - W'(1));
      assign nxt[gi]    = carry[gi+1] ? (at_max[gi] ? '0 : cnt_q[gi] + W'(1))
                                      : cnt_q[gi];
      assign cnt[gi]    = cnt_q[gi];
      if (gi > 0) begin : g_carry
        assign carry[gi] = carry[gi+1] & at_max[gi];
      end
    end
  endgenerate

  assign last = &at_max;

  always_comb begin
    for (int i = 0; i < NDIM; i++) begin
      cnt_d[i] = clr ? '0 : (inc ? nxt[i] : cnt_q[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NDIM; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NDIM; i++) cnt_q[i] <= cnt_d[i];
    end
  end

endmodule

// File: rtl/ub_port_sched_gen.sv
// ----------------------------------------------------------------------------
// ub_port_sched_gen
// Affine schedule generator for one unified-buffer port. After start it
// waits cfg_delay cycles, then walks the loop nest lexicographically,
// pulsing en every max(cfg_ii,1) cycles with the point in ctrl_vars and
// addr = offset + sum(ctrl_vars[i]*stride[i]) (mod 2^W).
// Ports:
//   clk, rst_n        clock / synchronous active-low reset
//   flush             restart to IDLE (beats start and stall)
//   start             launch a pass from IDLE or DONE (ignored while stalled)
//   stall             freeze everything; en forced low
//   cfg_extent/stride per-dimension trip count and address coefficient
//   cfg_offset        address base
//   cfg_delay         extra cycles before the first en
//   cfg_ii            en spacing (0 behaves as 1)
//   en, ctrl_vars, addr  registered, mutually aligned outputs
//   done              high while in DONE
// ----------------------------------------------------------------------------
module ub_port_sched_gen
  import ub_sched_pkg::*;
#(
  parameter int NDIM = NDIM_DEF,
  parameter int W    = W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         start,
  input  logic         stall,
  input  logic [W-1:0] cfg_extent [NDIM-1:0],
  input  logic [W-1:0] cfg_stride [NDIM-1:0],
  input  logic [W-1:0] cfg_offset,
  input  logic [W-1:0] cfg_delay,
  input  logic [W-1:0] cfg_ii,
  output logic         en,
  output logic [W-1:0] ctrl_vars  [NDIM-1:0],
  output logic [W-1:0] addr,
  output logic         done
);

  sched_state_e state_q, state_d;
  logic [W-1:0] ext_q    [NDIM-1:0];
  logic [W-1:0] ext_d    [NDIM-1:0];
  logic [W-1:0] stride_q [NDIM-1:0];
  logic [W-1:0] stride_d [NDIM-1:0];
  logic [W-1:0] offset_q, offset_d;
  logic [W-1:0] ii_q, ii_d;
  logic [W-1:0] dly_q, dly_d;
  logic [W-1:0] ii_cnt_q, ii_cnt_d;
  logic [W-1:0] addr_q, addr_d;
  logic         en_q, en_d;

  logic         nest_clr, nest_inc, nest_last;
  logic [W-1:0] nest_nxt [NDIM-1:0];
  logic [W-1:0] mac_nxt;
  logic         cfg_ext_zero;
  logic [W-1:0] cfg_ii_eff;

  ub_sched_nest_cnt #(.NDIM(NDIM), .W(W)) u_nest (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (nest_clr),
    .inc    (nest_inc),
    .extent (ext_q),
    .cnt    (ctrl_vars),
    .nxt    (nest_nxt),
    .last   (nest_last)
  );

  // Address of the point about to be loaded, so addr lands with en.
  always_comb begin
    mac_nxt = offset_q;
    for (int i = 0; i < NDIM; i++) mac_nxt = mac_nxt + nest_nxt[i] * stride_q[i];
  end

  always_comb begin
    cfg_ext_zero = 1'b0;
    for (int i = 0; i < NDIM; i++) cfg_ext_zero = cfg_ext_zero | (cfg_extent[i] == '0);
  end

  assign cfg_ii_eff = (cfg_ii == '0) ? W'(1) : cfg_ii;

  always_comb begin
    state_d  = state_q;
    ext_d    = ext_q;
    stride_d = stride_q;
    offset_d = offset_q;
    ii_d     = ii_q;
    dly_d    = dly_q;
    ii_cnt_d = ii_cnt_q;
    addr_d   = addr_q;
    en_d     = 1'b0;
    nest_clr = 1'b0;
    nest_inc = 1'b0;
    if (flush) begin
      state_d  = ST_IDLE;
      dly_d    = '0;
      ii_cnt_d = '0;
      addr_d   = '0;
      nest_clr = 1'b1;
    end else if (!stall) begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            ext_d    = cfg_extent;
            stride_d = cfg_stride;
            offset_d = cfg_offset;
            ii_d     = cfg_ii_eff;
            dly_d    = cfg_delay;
            ii_cnt_d = '0;
            if (cfg_ext_zero) begin
              state_d = ST_DONE;
            end else if (cfg_delay == '0) begin
              // Zero delay: point 0 issues on the start edge itself.
              state_d  = ST_RUN;
              en_d     = 1'b1;
              nest_clr = 1'b1;
              addr_d   = cfg_offset;
              ii_cnt_d = cfg_ii_eff - W'(1);
            end else begin
              state_d = ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (dly_q <= W'(1)) begin
            state_d  = ST_RUN;
            dly_d    = '0;
            en_d     = 1'b1;
            nest_clr = 1'b1;
            addr_d   = offset_q;
            ii_cnt_d = ii_q - W'(1);
          end else begin
            dly_d = dly_q - W'(1);
          end
        end
        ST_RUN: begin
          // Last point already issued: leave the cycle after its en.
          if (nest_last) begin
            state_d = ST_DONE;
          end else if (ii_cnt_q == '0) begin
            en_d     = 1'b1;
            nest_inc = 1'b1;
            addr_d   = mac_nxt;
            ii_cnt_d = ii_q - W'(1);
          end else begin
            ii_cnt_d = ii_cnt_q - W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      for (int i = 0; i < NDIM; i++) begin
        ext_q[i]    <= '0;
        stride_q[i] <= '0;
      end
      offset_q <= '0;
      ii_q     <= '0;
      dly_q    <= '0;
      ii_cnt_q <= '0;
      addr_q   <= '0;
      en_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      for (int i = 0; i < NDIM; i++) begin
        ext_q[i]    <= ext_d[i];
        stride_q[i] <= stride_d[i];
      end
      offset_q <= offset_d;
      ii_q     <= ii_d;
      dly_q    <= dly_d;
      ii_cnt_q <= ii_cnt_d;
      addr_q   <= addr_d;
      en_q     <= en_d;
    end
  end

  assign en   = en_q;
  assign addr = addr_q;
  assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_ub_port_sched_gen.sv
// ----------------------------------------------------------------------------
// tb_ub_port_sched_gen
// Scoreboard bench: each start pushes the full expected point sequence
// (point, address, cycle) computed by mixed-radix decomposition of the
// point index; a monitor pops and compares on every en.
// ----------------------------------------------------------------------------
module tb_ub_port_sched_gen;
  localparam int NDIM = 4;
  localparam int W    = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic         start = 1'b0;
  logic         stall = 1'b0;
  logic [W-1:0] cfg_extent [NDIM-1:0];
  logic [W-1:0] cfg_stride [NDIM-1:0];
  logic [W-1:0] cfg_offset, cfg_delay, cfg_ii;
  logic         en, done;
  logic [W-1:0] ctrl_vars [NDIM-1:0];
  logic [W-1:0] addr;

  ub_port_sched_gen #(.NDIM(NDIM), .W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .start      (start),
    .stall      (stall),
    .cfg_extent (cfg_extent),
    .cfg_stride (cfg_stride),
    .cfg_offset (cfg_offset),
    .cfg_delay  (cfg_delay),
    .cfg_ii     (cfg_ii),
    .en         (en),
    .ctrl_vars  (ctrl_vars),
    .addr       (addr),
    .done       (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [NDIM-1:0][W-1:0] ctrl;
    logic [W-1:0]           addr;
    int                     cyc;
    bit                     chk_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   popped = 0;
  int   exp_done_cyc = 0;
  bit   hold_chk = 1'b0;
  logic [W-1:0]           last_addr = '0;
  logic [NDIM-1:0][W-1:0] last_ctrl = '0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // Monitor: samples 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    if (rst_n && en) begin
      chk("en_after_stalled_edge", {63'd0, stall}, 64'd0);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_en: got en=1 addr=%0h required no en (cycle %0d)", addr, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("addr", addr, e.addr);
        for (int i = 0; i < NDIM; i++) chk("ctrl_vars", ctrl_vars[i], e.ctrl[i]);
        if (e.chk_cyc) chk("en_cycle", cyc, e.cyc);
        $display("en #%0d cycle %0d ctrl=%0d/%0d/%0d/%0d addr=%04h", popped, cyc,
                 ctrl_vars[0], ctrl_vars[1], ctrl_vars[2], ctrl_vars[3], addr);
        popped++;
        last_addr = e.addr;
        last_ctrl = e.ctrl;
        hold_chk  = 1'b1;
      end
    end else if (rst_n && hold_chk) begin
      chk("addr_hold", addr, last_addr);
      for (int i = 0; i < NDIM; i++) chk("ctrl_hold", ctrl_vars[i], last_ctrl[i]);
    end
  end

  task automatic set_cfg(input int e0, input int e1, input int e2, input int e3,
                         input int s0, input int s1, input int s2, input int s3,
                         input int off, input int dly, input int ii);
    cfg_extent[0] = W'(e0); cfg_extent[1] = W'(e1);
    cfg_extent[2] = W'(e2); cfg_extent[3] = W'(e3);
    cfg_stride[0] = W'(s0); cfg_stride[1] = W'(s1);
    cfg_stride[2] = W'(s2); cfg_stride[3] = W'(s3);
    cfg_offset = W'(off); cfg_delay = W'(dly); cfg_ii = W'(ii);
  endtask

  // Issue a start and push the reference sequence for the current cfg.
  task automatic start_pass(input bit chk_t);
    int n, iie, start_c;
    @(negedge clk);
    start_c = cyc;
    iie = (cfg_ii == 0) ? 1 : int'(cfg_ii);
    n = 1;
    for (int d = 0; d < NDIM; d++) n = n * int'(cfg_extent[d]);
    for (int k = 0; k < n; k++) begin
      exp_t e;
      int rem, acc;
      rem = k;
      acc = int'(cfg_offset);
      for (int d = NDIM - 1; d >= 0; d--) begin
        int ix;
        ix = rem % int'(cfg_extent[d]);
        rem = rem / int'(cfg_extent[d]);
        e.ctrl[d] = W'(ix);
        acc = acc + ix * int'(cfg_stride[d]);
      end
      e.addr = W'(acc);
      e.cyc = start_c + 1 + int'(cfg_delay) + k * iie;
      e.chk_cyc = chk_t;
      exp_q.push_back(e);
    end
    exp_done_cyc = (n == 0) ? start_c + 1
                            : start_c + 1 + int'(cfg_delay) + (n - 1) * iie + 1;
    $display("start cycle %0d: %0d points, delay %0d, ii %0d", start_c, n, cfg_delay, iie);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input bit chk_t, input bit rnd_stall);
    int t = 0;
    while (!done && t < 3000) begin
      stall = rnd_stall && ($urandom_range(0, 3) == 0);
      @(negedge clk);
      t++;
    end
    stall = 1'b0;
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout: got done=0 required done=1 within 3000 cycles");
    end else begin
      if (chk_t) chk("done_cycle", cyc, exp_done_cyc);
      chk("points_outstanding", exp_q.size(), 0);
      chk("en_in_done", {63'd0, en}, 64'd0);
      $display("done at cycle %0d", cyc);
    end
  endtask

  task automatic wait_popped(input int target);
    int t = 0;
    while (popped < target && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (popped < target) begin
      n_cmp++;
      n_bad++;
      $display("FAIL pop_timeout: got %0d en required %0d", popped, target);
    end
  endtask

  initial begin
    int p0;
    set_cfg(1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1);
    repeat (3) @(negedge clk);
    chk("rst_en", {63'd0, en}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_addr", addr, 0);
    for (int i = 0; i < NDIM; i++) chk("rst_ctrl", ctrl_vars[i], 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic nest, back-to-back en.
    set_cfg(1, 2, 2, 4, 0, 1024, 32, 1, 0, 0, 1);
    start_pass(1);
    wait_done(1, 0);

    // Delay and ii, restarted from DONE.
    set_cfg(1, 2, 2, 4, 0, 1024, 32, 1, 0, 5, 3);
    start_pass(1);
    wait_done(1, 0);

    // Four-cycle stall mid-run.
    set_cfg(1, 2, 2, 4, 0, 1024, 32, 1, 0, 0, 1);
    p0 = popped;
    start_pass(0);
    wait_popped(p0 + 5);
    stall = 1'b1;
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      chk("stall_en", {63'd0, en}, 64'd0);
    end
    stall = 1'b0;
    wait_done(0, 0);
    chk("stall_total", popped - p0, 16);

    // Zero extent: straight to DONE.
    set_cfg(1, 2, 0, 4, 0, 1024, 32, 1, 0, 0, 1);
    start_pass(1);
    wait_done(1, 0);

    // Flush (with a simultaneous start) after point 7, then replay.
    set_cfg(1, 2, 2, 4, 0, 1024, 32, 1, 0, 0, 1);
    p0 = popped;
    start_pass(1);
    wait_popped(p0 + 8);
    flush = 1'b1;
    start = 1'b1;
    exp_q.delete();
    hold_chk = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    start = 1'b0;
    chk("flush_en", {63'd0, en}, 64'd0);
    chk("flush_done", {63'd0, done}, 64'd0);
    for (int i = 0; i < NDIM; i++) chk("flush_ctrl", ctrl_vars[i], 0);
    repeat (4) @(negedge clk);
    chk("flush_idle_done", {63'd0, done}, 64'd0);
    start_pass(1);
    wait_done(1, 0);

    // Address wrap.
    set_cfg(1, 1, 1, 4, 0, 0, 0, 1, 16'hFFFF, 0, 1);
    start_pass(1);
    wait_done(1, 0);

    // Reset mid-run aborts the pass.
    set_cfg(1, 2, 2, 4, 0, 1024, 32, 1, 0, 2, 2);
    p0 = popped;
    start_pass(0);
    wait_popped(p0 + 3);
    rst_n = 1'b0;
    exp_q.delete();
    hold_chk = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_en", {63'd0, en}, 64'd0);
    chk("midrst_addr", addr, 0);
    for (int i = 0; i < NDIM; i++) chk("midrst_ctrl", ctrl_vars[i], 0);
    repeat (20) @(negedge clk);
    chk("midrst_done", {63'd0, done}, 64'd0);

    // Randomized passes; the later ones with random stalls.
    for (int r = 0; r < 8; r++) begin
      bit rs;
      rs = (r >= 4);
      set_cfg($urandom_range(1, 3), $urandom_range(1, 3), $urandom_range(1, 3),
              $urandom_range(1, 3), $urandom_range(0, 65535), $urandom_range(0, 65535),
              $urandom_range(0, 65535), $urandom_range(0, 65535), $urandom_range(0, 65535),
              $urandom_range(0, 4), $urandom_range(0, 3));
      start_pass(!rs);
      wait_done(!rs, rs);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
